muldiv_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit beside the ALU adder/subtractor in the execute stage.
- Executes MULT/MULTU/DIV/DIVU over 32 add/subtract iterations.
- Holds the architectural HI/LO registers that MFHI/MFLO read.
- Stalls the pipeline through `busy`.

---
 rtl/muldiv_unit_if.sv | 38 +++
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and muldiv_unit.
// Define MULDIV_HILO_WRITE_EN to add the MTHI/MTLO write port (hi_we, lo_we, wdata).
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_HILO_WRITE_EN
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );
    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
`else
    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );
    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
`endif
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; one add/sub step per cycle.
// Optional MTHI/MTLO write port enabled by defining MULDIV_HILO_WRITE_EN.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    state_e           state_q;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             zero_q;
    logic [WIDTH-1:0] mcand_q;
    logic [AW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             neg_a_c;
    logic             neg_b_c;
    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   trial_c;
    logic [AW-1:0]    prod_c;
    logic [WIDTH-1:0] quot_c;
    logic [WIDTH-1:0] rem_c;
    logic [AW-1:0]    acc_d;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    // Operand magnitudes, one iteration step, and the sign-corrected result.
    always_comb begin
        neg_a_c   = bus.op[0] & bus.a[WIDTH-1];
        neg_b_c   = bus.op[0] & bus.b[WIDTH-1];
        abs_a_c   = neg_a_c ? -bus.a : bus.a;
        abs_b_c   = neg_b_c ? -bus.b : bus.b;

        mul_sum_c = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        trial_c   = acc_q[AW-1:WIDTH-1] - {1'b0, mcand_q};

        if (!is_div_q) begin
            acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
        end else if (trial_c[WIDTH]) begin
            acc_d = {acc_q[AW-2:0], 1'b0};
        end else begin
            acc_d = {trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end

        prod_c = neg_res_q ? -acc_q : acc_q;
        quot_c = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_c  = neg_rem_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];

        // With a zero divisor the remainder ends as |a|, which the sign fix turns back into a.
        if (!is_div_q) begin
            hi_d = prod_c[AW-1:WIDTH];
            lo_d = prod_c[WIDTH-1:0];
        end else begin
            hi_d = rem_c;
            lo_d = zero_q ? '1 : quot_c;
        end
    end

    // Control FSM plus datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef MULDIV_HILO_WRITE_EN
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
`endif
                    if (bus.start) begin
                        is_div_q  <= bus.op[1];
                        neg_res_q <= neg_a_c ^ neg_b_c;
                        neg_rem_q <= neg_a_c;
                        zero_q    <= (bus.b == '0);
                        mcand_q   <= bus.op[1] ? abs_b_c : abs_a_c;
                        acc_q     <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a_c : abs_b_c)};
                        cnt_q     <= '0;
                        dz_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    dz_q    <= is_div_q & zero_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULDIV_HILO_WRITE_EN
    initial begin
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
    end
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result computed with 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint     sa;
        longint     sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ez = 1'b0;
        eh = '0;
        el = '0;
        case (op)
            2'd0: begin
                p  = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            2'd1: begin
                p  = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    el = '1;
                    eh = a;
                    ez = 1'b1;
                end else if (op == 2'd2) begin
                    el = a / b;
                    eh = a % b;
                end else begin
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                end
            end
        endcase
    endfunction

    // Issue one operation; optionally pulse a spurious start poke_at cycles after acceptance.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at);
        logic [31:0] eh, el, prev_hi, prev_lo;
        logic        ez;
        int          lat, busy_cnt;
        bit          hold_ok;
        model(op, a, b, eh, el, ez);
        @(negedge clk);
        prev_hi   = bus.hi;
        prev_lo   = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        check("done_low_after_start", 64'(bus.done), 64'd0);
        check("dz_cleared_on_start", 64'(bus.div_by_zero), 64'd0);
        lat      = 0;
        busy_cnt = bus.busy ? 1 : 0;
        hold_ok  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == poke_at) begin
                bus.start = 1'b1;
                bus.op    = 2'd0;
                bus.a     = 32'd1234;
                bus.b     = 32'd77;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (bus.hi !== prev_hi || bus.lo !== prev_lo) hold_ok = 1'b0;
        end
        check("latency", 64'(lat), 64'd33);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("hilo_hold", 64'(hold_ok), 64'd1);
        check("busy_at_done", 64'(bus.busy), 64'd0);
        check("hi", 64'(bus.hi), 64'(eh));
        check("lo", 64'(bus.lo), 64'(el));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(ez));
    endtask

    // Abort an operation with reset at cycle 10 and confirm nothing completes.
    task automatic run_reset_abort();
        int done_seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (k == 5) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_abort_busy", 64'(bus.busy), 64'd0);
        check("rst_abort_hi", 64'(bus.hi), 64'd0);
        check("rst_abort_lo", 64'(bus.lo), 64'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        check("rst_abort_no_done", 64'(done_seen), 64'd0);
        check("rst_abort_lo_after", 64'(bus.lo), 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz", 64'(bus.div_by_zero), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;

        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
        run_op(2'd1, 32'hFFFF_FFF9, 32'd3, 0);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'd2, 32'd100, 32'd7, 0);
        run_op(2'd2, 32'h64, 32'd0, 0);
        check("divu0_hi_const", 64'(bus.hi), 64'h64);
        run_op(2'd0, 32'd5, 32'd6, 5);
        check("ignored_start_lo", 64'(bus.lo), 64'd30);
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd3, 32'h8000_0001, 32'd0, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, (i % 5 == 0) ? int'($urandom_range(1, 32)) : 0);
        end

        run_reset_abort();
        run_op(2'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
